// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Serves one word per cycle on a hit. A miss stalls the pipeline, writes back a
// dirty victim if needed, then refills the line over the 256-bit memory port.
module dcache_controller #(
  parameter int NUM_LINES = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_i,
  input  logic         we_i,
  input  logic [31:0]  addr_i,
  input  logic [31:0]  data_i,
  output logic [31:0]  data_o,
  output logic         stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 32 - IW - 5;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;

  // Miss register. Only the line address is held: the CPU keeps we_i/data_i
  // stable while stalled and a store retires in IDLE once the line is resident.
  logic [TW-1:0]        miss_tag_q, miss_tag_d;
  logic [IW-1:0]        miss_idx_q, miss_idx_d;

  // Tag and data storage; not reset, guarded by the valid bits.
  logic [TW-1:0]        tag_mem  [NUM_LINES];
  logic [255:0]         data_mem [NUM_LINES];

  // Single write port shared by store hits and refills.
  logic                 wr_en;
  logic                 wr_tag_en;
  logic [IW-1:0]        wr_idx;
  logic [255:0]         wr_line;

  // CPU address split
  logic [2:0]           req_word;
  logic [IW-1:0]        req_idx;
  logic [TW-1:0]        req_tag;
  logic [255:0]         cur_line;
  logic [255:0]         merged_line;
  logic [31:0]          line_words [8];
  logic [31:0]          sel_word;
  logic                 hit;

  assign req_word = addr_i[4:2];
  assign req_idx  = addr_i[IW+4:5];
  assign req_tag  = addr_i[31:IW+5];
  assign cur_line = data_mem[req_idx];
  assign hit      = req_i & valid_q[req_idx] & (tag_mem[req_idx] == req_tag);

  // Byte offset within a word is always zero for word-aligned accesses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i[1:0];

  // Word slicing and store merge, one lane per 32-bit word of the line.
  for (genvar gi = 0; gi < 8; gi++) begin : g_word
    assign line_words[gi] = cur_line[32*gi +: 32];
    assign merged_line[32*gi +: 32] = (req_word == 3'(gi)) ? data_i : cur_line[32*gi +: 32];
  end

  assign sel_word = line_words[req_word];

  // State register, valid/dirty bits and miss register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
    end
  end

  // Tag/data array write port.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      data_mem[wr_idx] <= wr_line;
    end
    if (wr_tag_en) begin
      tag_mem[wr_idx] <= miss_tag_q;
    end
  end

  // Next-state logic, array write control and all outputs.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    miss_tag_d   = miss_tag_q;
    miss_idx_d   = miss_idx_q;
    wr_en        = 1'b0;
    wr_tag_en    = 1'b0;
    wr_idx       = req_idx;
    wr_line      = merged_line;
    data_o       = '0;
    stall_o      = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (hit) begin
            if (we_i) begin
              wr_en            = 1'b1;
              dirty_d[req_idx] = 1'b1;
            end else begin
              data_o = sel_word;
            end
          end else begin
            stall_o    = 1'b1;
            miss_tag_d = req_tag;
            miss_idx_d = req_idx;
            state_d    = (valid_q[req_idx] & dirty_q[req_idx]) ? S_WRITEBACK : S_ALLOCATE;
          end
        end
      end

      S_WRITEBACK: begin
        stall_o      = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_mem[miss_idx_q], miss_idx_q, 5'b0};
        mem_data_o   = data_mem[miss_idx_q];
        if (mem_ack_i) begin
          state_d = S_ALLOCATE;
        end
      end

      S_ALLOCATE: begin
        stall_o      = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {miss_tag_q, miss_idx_q, 5'b0};
        if (mem_ack_i) begin
          wr_en               = 1'b1;
          wr_tag_en           = 1'b1;
          wr_idx              = miss_idx_q;
          wr_line             = mem_data_i;
          valid_d[miss_idx_q] = 1'b1;
          dirty_d[miss_idx_q] = 1'b0;
          state_d             = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: a vector table for the main hit/miss
// scenarios, hand sequences for reset and reset-during-refill, and a
// random-latency run checked against a flat reference memory.
module tb_dcache_controller;

  logic         clk_i      = 1'b0;
  logic         rst_i      = 1'b1;
  logic         req_i      = 1'b0;
  logic         we_i       = 1'b0;
  logic [31:0]  addr_i     = '0;
  logic [31:0]  data_i     = '0;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i  = 1'b0;
  logic [31:0]  data_o;
  logic         stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  dcache_controller #(.NUM_LINES(16)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .data_i       (data_i),
    .data_o       (data_o),
    .stall_o      (stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  // Backing memory (4 KB of lines) and word-level reference image.
  logic [255:0] mem_model [128];
  logic [31:0]  ref_mem   [1024];

  int          lat_wb   = 1;
  int          lat_rd   = 1;
  bit          rand_lat = 1'b0;
  int          cur_lat  = 1;
  int          cnt      = 0;
  int          n_wb     = 0;
  int          n_fetch  = 0;
  logic [31:0] last_wb_addr    = '0;
  logic [31:0] last_fetch_addr = '0;
  logic [255:0] last_wb_data   = '0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: acks after the configured number of enabled cycles,
  // ack is a single-cycle pulse driven on the falling edge.
  always @(negedge clk_i) begin
    if (rst_i) begin
      mem_ack_i = 1'b0;
      cnt       = 0;
    end else begin
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        cnt       = 0;
      end
      if (mem_enable_o) begin
        cnt++;
        if (cnt == 1) begin
          if (rand_lat) cur_lat = int'($urandom_range(1, 4));
          else          cur_lat = mem_write_o ? lat_wb : lat_rd;
        end
        if (cnt >= cur_lat) begin
          check32("mem_addr_align", {27'b0, mem_addr_o[4:0]}, 32'h0);
          if (mem_write_o) begin
            mem_model[mem_addr_o[11:5]] = mem_data_o;
            n_wb++;
            last_wb_addr = mem_addr_o;
            last_wb_data = mem_data_o;
          end else begin
            mem_data_i = mem_model[mem_addr_o[11:5]];
            n_fetch++;
            last_fetch_addr = mem_addr_o;
          end
          mem_ack_i = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // One CPU access held until stall_o falls; returns stalled cycle count and
  // the load data seen in the completing cycle.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        output int stalls, output logic [31:0] rdata);
    @(negedge clk_i);
    req_i  = 1'b1;
    we_i   = we;
    addr_i = addr;
    data_i = data;
    #1;
    stalls = 0;
    while (stall_o && stalls < 200) begin
      @(negedge clk_i);
      #1;
      stalls++;
    end
    if (stalls >= 200) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: addr 0x%08h still stalled after %0d cycles", addr, stalls);
    end
    rdata = data_o;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          lwb;
    int          lrd;
    int          exp_stall;
    logic        chk_data;
    logic [31:0] exp_data;
    int          exp_wb;
    int          exp_fetch;
    logic [31:0] exp_wb_addr;
    int          wb_word;
    logic [31:0] exp_wb_val;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int          stalls;
    logic [31:0] rdata;
    int          nwb0;
    int          nf0;

    for (int l = 0; l < 128; l++) begin
      for (int w = 0; w < 8; w++) begin
        mem_model[l][32*w +: 32] = 32'(l * 8 + w);
      end
    end
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'(i);

    //           we    addr       data          lwb lrd stall chk   exp_data       wb f  wb_addr   wd wb_val
    vecs[0] = '{1'b0, 32'h040, 32'h0,          1, 10, 11, 1'b1, 32'h0000_0010, 0, 1, 32'h0,   0, 32'h0};
    vecs[1] = '{1'b0, 32'h044, 32'h0,          1, 1,  0,  1'b1, 32'h0000_0011, 0, 0, 32'h0,   0, 32'h0};
    vecs[2] = '{1'b1, 32'h048, 32'hDEAD_BEEF,  1, 1,  0,  1'b0, 32'h0,         0, 0, 32'h0,   0, 32'h0};
    vecs[3] = '{1'b0, 32'h048, 32'h0,          1, 1,  0,  1'b1, 32'hDEAD_BEEF, 0, 0, 32'h0,   0, 32'h0};
    vecs[4] = '{1'b0, 32'h240, 32'h0,          3, 2,  6,  1'b1, 32'h0000_0090, 1, 1, 32'h040, 2, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 32'h0C8, 32'h1234_5678,  1, 4,  5,  1'b0, 32'h0,         0, 1, 32'h0,   0, 32'h0};
    vecs[6] = '{1'b0, 32'h0C8, 32'h0,          1, 1,  0,  1'b1, 32'h1234_5678, 0, 0, 32'h0,   0, 32'h0};
    vecs[7] = '{1'b0, 32'h0CC, 32'h0,          1, 1,  0,  1'b1, 32'h0000_0033, 0, 0, 32'h0,   0, 32'h0};
    vecs[8] = '{1'b0, 32'h2C8, 32'h0,          1, 1,  3,  1'b1, 32'h0000_00B2, 1, 1, 32'h0C0, 2, 32'h1234_5678};
    vecs[9] = '{1'b0, 32'h048, 32'h0,          1, 2,  3,  1'b1, 32'hDEAD_BEEF, 0, 1, 32'h0,   0, 32'h0};

    // Reset state of all outputs.
    repeat (2) @(negedge clk_i);
    #1;
    check32("rst_stall",      {31'b0, stall_o},      32'h0);
    check32("rst_data",       data_o,                32'h0);
    check32("rst_mem_enable", {31'b0, mem_enable_o}, 32'h0);
    check32("rst_mem_write",  {31'b0, mem_write_o},  32'h0);
    check32("rst_mem_addr",   mem_addr_o,            32'h0);
    check32("rst_mem_data",   32'(|mem_data_o),      32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Table-driven main scenarios.
    for (int i = 0; i < 10; i++) begin
      lat_wb = vecs[i].lwb;
      lat_rd = vecs[i].lrd;
      nwb0   = n_wb;
      nf0    = n_fetch;
      access(vecs[i].we, vecs[i].addr, vecs[i].data, stalls, rdata);
      if (vecs[i].we) ref_mem[vecs[i].addr[11:2]] = vecs[i].data;
      check32($sformatf("v%0d_stall", i), 32'(stalls), 32'(vecs[i].exp_stall));
      if (vecs[i].chk_data) check32($sformatf("v%0d_data", i), rdata, vecs[i].exp_data);
      check32($sformatf("v%0d_nwb", i),    32'(n_wb - nwb0),   32'(vecs[i].exp_wb));
      check32($sformatf("v%0d_nfetch", i), 32'(n_fetch - nf0), 32'(vecs[i].exp_fetch));
      if (vecs[i].exp_fetch != 0)
        check32($sformatf("v%0d_fetch_addr", i), last_fetch_addr, vecs[i].addr & ~32'h1F);
      if (vecs[i].exp_wb != 0) begin
        check32($sformatf("v%0d_wb_addr", i), last_wb_addr, vecs[i].exp_wb_addr);
        check32($sformatf("v%0d_wb_word", i), last_wb_data[32*vecs[i].wb_word +: 32], vecs[i].exp_wb_val);
      end
    end
    // The store-allocated line kept its fetched neighbours when written back.
    check32("wb_merge_neighbour", last_wb_data[127:96], 32'h0000_0033);

    // Reset asserted in the middle of a refill.
    lat_rd = 20;
    @(negedge clk_i);
    req_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = 32'h300;
    #1;
    check32("midrst_miss_stall", {31'b0, stall_o}, 32'h1);
    repeat (2) @(negedge clk_i);
    #1;
    check32("midrst_alloc_en",   {31'b0, mem_enable_o}, 32'h1);
    check32("midrst_alloc_wr",   {31'b0, mem_write_o},  32'h0);
    check32("midrst_alloc_addr", mem_addr_o,            32'h300);
    #1;
    rst_i = 1'b1;
    req_i = 1'b0;
    #1;
    check32("midrst_en_drop",    {31'b0, mem_enable_o}, 32'h0);
    check32("midrst_stall_drop", {31'b0, stall_o},      32'h0);
    check32("midrst_addr_zero",  mem_addr_o,            32'h0);
    @(negedge clk_i);
    rst_i  = 1'b0;
    lat_rd = 2;
    nf0    = n_fetch;
    access(1'b0, 32'h300, 32'h0, stalls, rdata);
    check32("postrst_stall",  32'(stalls),        32'd3);
    check32("postrst_data",   rdata,              32'h0000_00C0);
    check32("postrst_nfetch", 32'(n_fetch - nf0), 32'd1);

    // Alternating hits and misses over all indices with random latency.
    rand_lat = 1'b1;
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      logic [31:0] d;
      logic        w;
      a = 32'($urandom_range(0, 2)) * 32'h200 + 32'($urandom_range(0, 15)) * 32'h20
          + 32'($urandom_range(0, 7)) * 32'h4;
      d = $urandom;
      w = 1'($urandom_range(0, 1));
      access(w, a, d, stalls, rdata);
      if (w) ref_mem[a[11:2]] = d;
      else   check32($sformatf("rand%0d_load_0x%03h", n, a), rdata, ref_mem[a[11:2]]);
      // Repeat the same address: must now hit without stalling.
      access(1'b0, a, 32'h0, stalls, rdata);
      check32($sformatf("rand%0d_rehit_stall", n), 32'(stalls), 32'd0);
      check32($sformatf("rand%0d_rehit_data", n),  rdata,       ref_mem[a[11:2]]);
    end

    @(negedge clk_i);
    req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
